// File: rtl/uart_tx_fifo_if.sv
// Write handshake plus serial line and status signals of the FIFO-buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;
  logic [CW-1:0]        fifo_count;

  modport master (output tx_data, tx_valid,
                  input  tx_ready, tx, busy, tx_done, fifo_count);
  modport slave  (input  tx_data, tx_valid,
                  output tx_ready, tx, busy, tx_done, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frames go out back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic           hwclk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_next;
  logic [BW-1:0]        baud_cnt, baud_next;
  logic [3:0]           bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit, par_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] head;
  logic                 head_par, push, pop, line, last_stop, baud_end;
  logic                 tx_q, done_d, done_q;

  assign head         = mem[rd_ptr];
  assign head_par     = (PARITY == 1) ? ~^head : ^head;
  assign baud_end     = (baud_cnt == BAUD_LAST);
  assign bus.tx_ready = (count < CW'(FIFO_DEPTH));
  assign push         = bus.tx_valid && bus.tx_ready;
  assign bus.tx       = tx_q;
  assign bus.tx_done  = done_q;
  assign bus.fifo_count = count;
  // done_d covers the cycle where the last stop bit is still on the registered line
  assign bus.busy     = (state != S_IDLE) || (count != '0) || done_d;

  always_comb begin
    state_next = state;
    baud_next  = baud_end ? '0 : baud_cnt + BW'(1);
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    par_next   = par_bit;
    pop        = 1'b0;
    line       = 1'b1;
    last_stop  = 1'b0;
    case (state)
      S_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = head_par;
          state_next = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (baud_end) state_next = S_DATA;
      end
      S_DATA: begin
        line = shift_reg[0];
        if (baud_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        line = par_bit;
        if (baud_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            last_stop = 1'b1;
            bit_next  = '0;
            // A queued word starts its frame on the very next edge, leaving no idle gap
            if (count != '0) begin
              pop        = 1'b1;
              shift_next = head;
              par_next   = head_par;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_cnt + 4'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx_q      <= 1'b1;
      done_d    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      par_bit   <= par_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      tx_q   <= line;
      done_d <= last_stop;
      done_q <= done_d;
    end
  end

  always_ff @(posedge hwclk) begin
    if (!rst && push) mem[wr_ptr] <= bus.tx_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a cycle table plus hand-written sequences, with a mid-bit
// sampling receiver checking every frame on an 8N1 instance and a 7E2 instance (DIV = 4).
module tb_uart_tx_fifo;
  localparam int DIVB = 4;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [8:0] data;
    logic       tx;
    logic       ready;
    logic       busy;
    logic       done;
    logic [2:0] count;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rst_gen = 0;
  logic [8:0] rx_q0[$];
  logic [8:0] rx_q1[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_p ();

  uart_tx_fifo #(.CLK_HZ(12000000), .BAUD(3000000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    dut (.hwclk(clk), .rst(rst), .bus(bus));

  uart_tx_fifo #(.CLK_HZ(12000000), .BAUD(3000000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_p (.hwclk(clk), .rst(rst), .bus(bus_p));

  always @(posedge clk) if (rst) rst_gen <= rst_gen + 1;

  function automatic logic line_of(input int ch);
    return (ch == 0) ? bus.tx : bus_p.tx;
  endfunction

  // Expected line level per clock cycle for one whole frame, cycle 0 in bit 0
  function automatic logic [63:0] frame_vec(input logic [8:0] data, input int nbits,
                                            input int par, input int nstop);
    logic [15:0] bits;
    logic [63:0] v;
    int nb;
    bits = '0;
    v = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1 + i] = data[i];
    nb = 1 + nbits;
    if (par != 0) begin
      bits[nb] = (par == 1) ? ~^data : ^data;
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int j = 0; j < nb; j++)
      for (int c = 0; c < DIVB; c++) v[DIVB * j + c] = bits[j];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int ch, input logic r, input logic v, input logic [8:0] d);
    rst            = r;
    bus.tx_valid   = (ch == 0) && v;
    bus.tx_data    = d[7:0];
    bus_p.tx_valid = (ch == 1) && v;
    bus_p.tx_data  = d[6:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkReceived(input string name, input int ch);
    int n;
    logic [8:0] got;
    n = (ch == 0) ? rx_q0.size() : rx_q1.size();
    checkOutput({name, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      got = (ch == 0) ? rx_q0[i] : rx_q1[i];
      checkOutput($sformatf("%s_word%0d", name, i), 64'(got), 64'(exp_q[i]));
    end
  endtask

  // Receiver samples each bit mid-period; a reset seen during a frame discards that frame
  task automatic rx_run(input int ch, input int nbits, input int par, input int nstop);
    logic [8:0] word;
    logic ok;
    int gen;
    forever begin
      @(negedge clk);
      if (!rst && line_of(ch) == 1'b0) begin
        gen  = rst_gen;
        word = '0;
        repeat (2) @(negedge clk);
        ok = (line_of(ch) == 1'b0);
        for (int i = 0; i < nbits; i++) begin
          repeat (DIVB) @(negedge clk);
          word[i] = line_of(ch);
        end
        if (par != 0) begin
          repeat (DIVB) @(negedge clk);
          ok = ok && (line_of(ch) == ((par == 1) ? ~^word : ^word));
        end
        for (int i = 0; i < nstop; i++) begin
          repeat (DIVB) @(negedge clk);
          ok = ok && line_of(ch);
        end
        if (gen == rst_gen) begin
          checkOutput($sformatf("rx%0d_frame_bits", ch), 64'(ok), 64'(1));
          if (ch == 0) rx_q0.push_back(word);
          else rx_q1.push_back(word);
        end
      end
    end
  endtask

  initial rx_run(0, 8, 0, 1);
  initial rx_run(1, 7, 2, 2);

  initial begin
    vec_t vecs[13];
    logic [63:0] cap;
    int done_at, done_n, busy_after, any_low;
    int done_edges[$];

    // rst, valid, data, then expected tx, ready, busy, done, count after the edge
    vecs[0]  = '{1'b1, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 9'h099, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 9'h055, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b0, 9'h0FF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 1'b1, 9'h0A1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, 1'b1, 9'h0A2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    vecs[6]  = '{1'b0, 1'b1, 9'h0A3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 9'h0A4, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[8]  = '{1'b0, 1'b1, 9'h0AA, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[9]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[11] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[12] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};

    bus.tx_valid = 1'b0;   bus.tx_data = '0;
    bus_p.tx_valid = 1'b0; bus_p.tx_data = '0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, vecs[i].rst, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d_tx", i), 64'(bus.tx), 64'(vecs[i].tx));
      checkOutput($sformatf("vec%0d_ready", i), 64'(bus.tx_ready), 64'(vecs[i].ready));
      checkOutput($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_done", i), 64'(bus.tx_done), 64'(vecs[i].done));
      checkOutput($sformatf("vec%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].count));
    end
    // Table ended on edge N+10; the pop from full happens on edge N+41
    repeat (30) applyStimulus(0, 1'b0, 1'b0, 9'h000);
    applyStimulus(0, 1'b0, 1'b1, 9'h0BB);
    checkOutput("full_pop_count", 64'(bus.fifo_count), 64'(3));
    checkOutput("full_pop_ready", 64'(bus.tx_ready), 64'(1));
    repeat (200) applyStimulus(0, 1'b0, 1'b0, 9'h000);
    exp_q.delete();
    exp_q.push_back(9'h055); exp_q.push_back(9'h0A1); exp_q.push_back(9'h0A2);
    exp_q.push_back(9'h0A3); exp_q.push_back(9'h0A4);
    checkReceived("full_rx", 0);
    checkOutput("full_busy_end", 64'(bus.busy), 64'(0));

    // Single 8N1 frame: exact line timing and tx_done position
    applyStimulus(0, 1'b1, 1'b0, 9'h000);
    rx_q0.delete();
    applyStimulus(0, 1'b0, 1'b1, 9'h055);
    cap = '0; done_at = -1; done_n = 0; busy_after = 1;
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 9'h000);
      if (k >= 2 && k <= 41) cap[k - 2] = bus.tx;
      if (bus.tx_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k == 43) busy_after = bus.busy;
    end
    checkOutput("8n1_line", cap, frame_vec(9'h055, 8, 0, 1));
    checkOutput("8n1_done_cycle", 64'(done_at), 64'(42));
    checkOutput("8n1_done_pulses", 64'(done_n), 64'(1));
    checkOutput("8n1_busy_after", 64'(busy_after), 64'(0));
    exp_q.delete(); exp_q.push_back(9'h055);
    checkReceived("8n1_rx", 0);

    // Burst of five consecutive writes: frames must run back-to-back
    applyStimulus(0, 1'b1, 1'b0, 9'h000);
    rx_q0.delete();
    for (int j = 0; j < 5; j++) applyStimulus(0, 1'b0, 1'b1, 9'(j + 1));
    checkOutput("burst_count", 64'(bus.fifo_count), 64'(4));
    checkOutput("burst_ready", 64'(bus.tx_ready), 64'(0));
    done_edges.delete();
    for (int k = 5; k <= 260; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 9'h000);
      if (bus.tx_done) done_edges.push_back(k);
    end
    checkOutput("burst_done_pulses", 64'(done_edges.size()), 64'(5));
    if (done_edges.size() > 0) checkOutput("burst_first_done", 64'(done_edges[0]), 64'(42));
    for (int i = 1; i < done_edges.size(); i++)
      checkOutput($sformatf("burst_gap%0d", i), 64'(done_edges[i] - done_edges[i - 1]), 64'(40));
    exp_q.delete();
    for (int j = 1; j <= 5; j++) exp_q.push_back(9'(j));
    checkReceived("burst_rx", 0);

    // 7E2 frame on the parity instance
    applyStimulus(1, 1'b1, 1'b0, 9'h000);
    rx_q1.delete();
    applyStimulus(1, 1'b0, 1'b1, 9'h041);
    cap = '0; done_at = -1; done_n = 0;
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1, 1'b0, 1'b0, 9'h000);
      if (k >= 2 && k <= 45) cap[k - 2] = bus_p.tx;
      if (bus_p.tx_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
    end
    checkOutput("7e2_line", cap, frame_vec(9'h041, 7, 2, 2));
    checkOutput("7e2_done_cycle", 64'(done_at), 64'(46));
    checkOutput("7e2_done_pulses", 64'(done_n), 64'(1));
    exp_q.delete(); exp_q.push_back(9'h041);
    checkReceived("7e2_rx", 1);

    // Reset during data bit 3 with two words queued
    applyStimulus(0, 1'b1, 1'b0, 9'h000);
    rx_q0.delete();
    applyStimulus(0, 1'b0, 1'b1, 9'h012);
    applyStimulus(0, 1'b0, 1'b1, 9'h034);
    applyStimulus(0, 1'b0, 1'b1, 9'h056);
    checkOutput("abort_queued", 64'(bus.fifo_count), 64'(2));
    repeat (16) applyStimulus(0, 1'b0, 1'b0, 9'h000);
    checkOutput("abort_bit3_line", 64'(bus.tx), 64'(0));
    applyStimulus(0, 1'b1, 1'b0, 9'h000);
    checkOutput("abort_tx", 64'(bus.tx), 64'(1));
    checkOutput("abort_count", 64'(bus.fifo_count), 64'(0));
    checkOutput("abort_ready", 64'(bus.tx_ready), 64'(1));
    checkOutput("abort_busy", 64'(bus.busy), 64'(0));
    done_n = 0; any_low = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 9'h000);
      if (bus.tx_done) done_n++;
      if (!bus.tx) any_low = 1;
    end
    checkOutput("abort_no_done", 64'(done_n), 64'(0));
    checkOutput("abort_line_idle", 64'(any_low), 64'(0));
    exp_q.delete();
    checkReceived("abort_rx", 0);
    applyStimulus(0, 1'b0, 1'b1, 9'h033);
    done_n = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 9'h000);
      if (bus.tx_done) done_n++;
    end
    checkOutput("post_reset_done", 64'(done_n), 64'(1));
    exp_q.push_back(9'h033);
    checkReceived("post_reset_rx", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
